// File: rtl/dma_read_req_arbiter.sv
// Round-robin arbiter sharing one PCIe DMA read request port among channels,
// throttled by a limit on outstanding non-posted reads.
module dma_read_req_arbiter #(
    parameter int p_requesters      = 2,
    parameter int p_max_outstanding = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [32*p_requesters-1:0] req_addr,
    input  logic [10*p_requesters-1:0] req_len,
    input  logic [p_requesters-1:0]    req_valid,
    output logic [p_requesters-1:0]    req_done,
    output logic [7:0]                 req_tag,
    output logic [31:0]                dma_read_addr,
    output logic [9:0]                 dma_read_len,
    output logic                       dma_read_valid,
    input  logic                       dma_read_done,
    input  logic [7:0]                 current_tag,
    input  logic                       cpl_done,
    output logic [5:0]                 outstanding,
    output logic                       err_underflow
);

    localparam int IW = (p_requesters > 1) ? $clog2(p_requesters) : 1;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t          state;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   cand;
    logic            found;
    logic            can_issue;
    logic            accept;

    assign can_issue = outstanding < 6'(p_max_outstanding);
    assign accept    = (state == ISSUE) && dma_read_done;

    // Search starts one past the previous winner and wraps.
    always_comb begin
        found  = 1'b0;
        winner = last_grant;
        cand   = last_grant;
        for (int k = 0; k < p_requesters; k++) begin
            cand = (cand == IW'(p_requesters - 1)) ? '0 : cand + 1'b1;
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        req_done = '0;
        req_tag  = '0;
        if (accept) begin
            req_done[grant] = 1'b1;
            req_tag         = current_tag;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            grant          <= '0;
            last_grant     <= IW'(p_requesters - 1);
            dma_read_addr  <= '0;
            dma_read_len   <= '0;
            dma_read_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found && can_issue) begin
                        dma_read_addr  <= req_addr[32*winner +: 32];
                        dma_read_len   <= req_len[10*winner +: 10];
                        grant          <= winner;
                        dma_read_valid <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (dma_read_done) begin
                        dma_read_valid <= 1'b0;
                        last_grant     <= grant;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // An issue and a completion in the same cycle cancel out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else if (accept && !cpl_done) begin
            outstanding <= outstanding + 6'd1;
        end else if (!accept && cpl_done) begin
            if (outstanding == '0) begin
                err_underflow <= 1'b1;
            end else begin
                outstanding <= outstanding - 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_dma_read_req_arbiter.sv
// Scoreboard bench for dma_read_req_arbiter with a behavioural TX engine
// driven from a single stimulus thread.
module tb_dma_read_req_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [63:0] req_addr;
    logic [19:0] req_len;
    logic [1:0]  req_valid;
    logic [1:0]  req_done;
    logic [7:0]  req_tag;
    logic [31:0] dma_read_addr;
    logic [9:0]  dma_read_len;
    logic        dma_read_valid;
    logic        dma_read_done;
    logic [7:0]  current_tag;
    logic        cpl_done;
    logic [5:0]  outstanding;
    logic        err_underflow;

    typedef struct {
        int          ch;
        logic [31:0] addr;
        logic [9:0]  len;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    dma_read_req_arbiter #(
        .p_requesters(2),
        .p_max_outstanding(8)
    ) u_dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .req_addr(req_addr),
        .req_len(req_len),
        .req_valid(req_valid),
        .req_done(req_done),
        .req_tag(req_tag),
        .dma_read_addr(dma_read_addr),
        .dma_read_len(dma_read_len),
        .dma_read_valid(dma_read_valid),
        .dma_read_done(dma_read_done),
        .current_tag(current_tag),
        .cpl_done(cpl_done),
        .outstanding(outstanding),
        .err_underflow(err_underflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic [31:0] a,
                           input logic [9:0] l, input logic push);
        exp_t e;
        req_addr[32*ch +: 32] = a;
        req_len[10*ch +: 10]  = l;
        req_valid[ch]         = 1'b1;
        if (push) begin
            e.ch   = ch;
            e.addr = a;
            e.len  = l;
            sb.push_back(e);
        end
    endtask

    // Waits for the strobe, checks it against the scoreboard, then accepts
    // it after lat cycles; returns in the cycle after dma_read_done.
    task automatic tx_accept(input logic [7:0] tag, input int lat,
                             input logic cpl);
        exp_t e;
        int   n = 0;
        while (!dma_read_valid && n < 20) begin
            tick();
            n++;
        end
        chk("issue_timeout", dma_read_valid, 1);
        if (!dma_read_valid) return;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("addr", dma_read_addr, e.addr);
        chk("len", dma_read_len, e.len);
        for (int i = 1; i < lat; i++) begin
            tick();
            chk("valid_hold", dma_read_valid, 1);
            chk("addr_hold", dma_read_addr, e.addr);
        end
        dma_read_done = 1'b1;
        current_tag   = tag;
        cpl_done      = cpl;
        #1;
        chk("req_done", req_done, 64'(1) << e.ch);
        chk("req_tag", req_tag, tag);
        tick();
        dma_read_done = 1'b0;
        current_tag   = '0;
        cpl_done      = 1'b0;
        chk("valid_clr", dma_read_valid, 0);
    endtask

    initial begin
        i_rst         = 1'b1;
        req_addr      = '0;
        req_len       = '0;
        req_valid     = '0;
        dma_read_done = 1'b0;
        current_tag   = '0;
        cpl_done      = 1'b0;
        tick();
        tick();
        chk("rst_valid", dma_read_valid, 0);
        chk("rst_addr", dma_read_addr, 0);
        chk("rst_len", dma_read_len, 0);
        chk("rst_done", req_done, 0);
        chk("rst_outst", outstanding, 0);
        chk("rst_err", err_underflow, 0);
        i_rst = 1'b0;

        // Single request, accepted after 3 strobe cycles.
        set_req(0, 32'h1000_0000, 10'd32, 1'b1);
        tick();
        chk("lat_valid", dma_read_valid, 1);
        tx_accept(8'h05, 3, 1'b0);
        req_valid = '0;
        chk("single_outst", outstanding, 1);

        // Issue and completion in the same cycle.
        set_req(1, 32'h2000_0040, 10'd0, 1'b1);
        tx_accept(8'h11, 1, 1'b1);
        req_valid = '0;
        tick();
        chk("simul_outst", outstanding, 1);

        // Stray done in IDLE must be ignored.
        dma_read_done = 1'b1;
        #1;
        chk("stray_done", req_done, 0);
        tick();
        dma_read_done = 1'b0;
        chk("stray_outst", outstanding, 1);

        cpl_done = 1'b1;
        tick();
        cpl_done = 1'b0;
        chk("cpl_outst", outstanding, 0);
        chk("no_err", err_underflow, 0);

        // Completion at zero: sticky error.
        cpl_done = 1'b1;
        tick();
        cpl_done = 1'b0;
        chk("uf_outst", outstanding, 0);
        chk("uf_err", err_underflow, 1);
        tick();
        chk("uf_sticky", err_underflow, 1);

        // Fairness: both channels stay requesting for six grants.
        set_req(0, 32'hA000_0000, 10'd16, 1'b1);
        set_req(1, 32'hB000_0000, 10'd0, 1'b1);
        for (int g = 0; g < 6; g++) begin
            tx_accept(8'(8'h20 + g), 1 + (g % 3), 1'b0);
            if (g < 4)
                set_req(g % 2, 32'((g % 2 ? 32'hB000_0000 : 32'hA000_0000)
                        + 32'h100 * (g + 1)), 10'(g + 3), 1'b1);
        end
        req_valid = '0;
        tick();
        chk("fair_outst", outstanding, 6);
        chk("fair_err", err_underflow, 1);

        // Throttle at the limit of 8.
        set_req(0, 32'hC000_0000, 10'd1, 1'b1);
        tx_accept(8'h30, 1, 1'b0);
        set_req(0, 32'hC000_1000, 10'd2, 1'b1);
        tx_accept(8'h31, 1, 1'b0);
        set_req(0, 32'hC000_2000, 10'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("thr_hold", dma_read_valid, 0);
        end
        chk("thr_max", outstanding, 8);
        cpl_done = 1'b1;
        tick();
        cpl_done = 1'b0;
        chk("thr_dec", outstanding, 7);
        chk("thr_c1", dma_read_valid, 0);
        tick();
        chk("thr_c2", dma_read_valid, 1);
        tx_accept(8'h32, 1, 1'b0);
        req_valid = '0;
        chk("thr_full", outstanding, 8);

        // Reset while a request is in ISSUE.
        set_req(1, 32'hD000_0000, 10'd4, 1'b0);
        cpl_done = 1'b1;
        tick();
        cpl_done = 1'b0;
        tick();
        chk("pre_rst_valid", dma_read_valid, 1);
        set_req(0, 32'hE000_0000, 10'd5, 1'b1);
        i_rst = 1'b1;
        tick();
        chk("mid_rst_done", req_done, 0);
        i_rst = 1'b0;
        chk("mid_rst_valid", dma_read_valid, 0);
        chk("mid_rst_addr", dma_read_addr, 0);
        chk("mid_rst_len", dma_read_len, 0);
        chk("mid_rst_outst", outstanding, 0);
        chk("mid_rst_err", err_underflow, 0);
        tx_accept(8'h40, 2, 1'b0);
        req_valid = '0;
        chk("post_rst_outst", outstanding, 1);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
